// File: rtl/sram_ctrl_pkg.sv
// Shared constants, state encoding and request-check helper for the SRAM bus controller.
package sram_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam int unsigned SRAM_WORDS  = 262144;
  localparam int unsigned SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  // Halves must sit on even bytes, words on 4-byte boundaries.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Byte-lane steering: request size/offset to byte enables and replicated store data,
// and SRAM read word back to right-aligned, zero-extended load data.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  i_wsize,
  input  logic [1:0]  i_woff,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_rsize,
  input  logic [1:0]  i_roff,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_rshift;

  always_comb begin
    o_be    = 4'h0;
    o_wdata = i_wdata;
    case (i_wsize)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_woff;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_be    = 4'b0011 << i_woff;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SIZE_WORD: o_be = 4'hF;
      default:   o_be = 4'h0;
    endcase
  end

  assign w_rshift = i_rdata >> {i_roff, 3'b000};

  always_comb begin
    o_rdata = 32'h0;
    case (i_rsize)
      SIZE_BYTE: o_rdata = {24'h0, w_rshift[7:0]};
      SIZE_HALF: o_rdata = {16'h0, w_rshift[15:0]};
      SIZE_WORD: o_rdata = w_rshift;
      default:   o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-outstanding request/response front end for the 1 MB on-chip SRAM: range/alignment
// checking, lane-steered word access, single-beat response and saturating error counter.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  output logic [3:0]             sram_be,
  output logic                   sram_we,
  output logic                   sram_re,
  input  logic [31:0]            sram_rdata,
  output logic [ERR_CNT_W-1:0]   err_count
);

  state_e                 r_state, w_state_next;
  logic [1:0]             r_off, r_size;
  logic                   r_write, r_err;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [31:0]            r_sram_wdata;
  logic [3:0]             r_sram_be;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic        w_accept, w_req_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_req_err = (req_addr[31:20] != BASE_ADDR[31:20]) || (req_size == SIZE_RSVD) ||
                     is_misaligned(req_size, req_addr[1:0]);

  sram_lane_align u_lane_align (
    .i_wsize (req_size),
    .i_woff  (req_addr[1:0]),
    .i_wdata (req_wdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .i_rsize (r_size),
    .i_roff  (r_off),
    .i_rdata (sram_rdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_next = w_req_err ? RESP : ISSUE;
      ISSUE:   w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_off        <= 2'b00;
      r_size       <= SIZE_BYTE;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'h0;
      r_sram_be    <= 4'h0;
      r_err_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_off   <= req_addr[1:0];
        r_size  <= req_size;
        r_write <= req_write;
        r_err   <= w_req_err;
        if (w_req_err) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_sram_addr <= {2'b00, req_addr[19:2]};
          r_sram_be   <= req_write ? w_be : 4'h0;
          if (req_write) r_sram_wdata <= w_wdata;
        end
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign rsp_err    = rsp_valid && r_err;
  // sram_rdata is held by the macro while re=0, so the load data stays stable through RESP.
  assign rsp_rdata  = (rsp_valid && !r_err && !r_write) ? w_rdata : 32'h0;
  assign sram_we    = (r_state == ISSUE) && r_write;
  assign sram_re    = (r_state == ISSUE) && !r_write;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_be    = r_sram_be;
  assign err_count  = r_err_cnt;

endmodule
